// File: rtl/sm3_pkg.sv
// Shared SM3 constants, word-level helper functions and datapath types
// for the iterative compression-function core.
package sm3_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned HASH_W  = 256;
    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned WIN_N   = 16;
    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned J_W     = 6;

    localparam logic [HASH_W-1:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    localparam logic [WORD_W-1:0] T_LO = 32'h79cc4519;
    localparam logic [WORD_W-1:0] T_HI = 32'h7a879d8a;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working variables; A sits in the MSBs so the struct lines up with iv/hash_out
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] f;
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] h;
    } sm3_regs_t;

    // Message window: element i holds W(j+i) for the current round j
    typedef logic [WIN_N-1:0][WORD_W-1:0] sm3_win_t;

    function automatic logic [WORD_W-1:0] rol32(input logic [WORD_W-1:0] x,
                                                input logic [4:0]        n);
        logic [2*WORD_W-1:0] t;
        t = {x, x} << n;
        return t[2*WORD_W-1:WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] p0(input logic [WORD_W-1:0] x);
        return x ^ rol32(x, 5'd9) ^ rol32(x, 5'd17);
    endfunction

    function automatic logic [WORD_W-1:0] p1(input logic [WORD_W-1:0] x);
        return x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
    endfunction

    function automatic logic [WORD_W-1:0] ff(input logic              hi,
                                             input logic [WORD_W-1:0] x,
                                             input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
        return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
    endfunction

    function automatic logic [WORD_W-1:0] gg(input logic              hi,
                                             input logic [WORD_W-1:0] x,
                                             input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
        return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
    endfunction

    // Big-endian block word 0 lands in window slot 0
    function automatic sm3_win_t load_win(input logic [BLOCK_W-1:0] blk);
        sm3_win_t w;
        w = {<<WORD_W{blk}};
        return w;
    endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 round plus one step of the on-the-fly message
// expansion window.
module sm3_round
    import sm3_pkg::*;
(
    input  sm3_regs_t        regs_in,
    input  sm3_win_t         win_in,
    input  logic [J_W-1:0]   j,
    output sm3_regs_t        regs_nxt_c,
    output sm3_win_t         win_nxt_c
);

    logic              hi;
    logic [WORD_W-1:0] tj;
    logic [WORD_W-1:0] a12;
    logic [WORD_W-1:0] ss1;
    logic [WORD_W-1:0] ss2;
    logic [WORD_W-1:0] tt1;
    logic [WORD_W-1:0] tt2;
    logic [WORD_W-1:0] w_j;
    logic [WORD_W-1:0] w_p;
    logic [WORD_W-1:0] w_new;

    always_comb begin
        hi  = (j >= J_W'(16));
        tj  = hi ? T_HI : T_LO;
        a12 = rol32(regs_in.a, 5'd12);
        ss1 = rol32(a12 + regs_in.e + rol32(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;

        w_j = win_in[0];
        w_p = win_in[0] ^ win_in[4];
        tt1 = ff(hi, regs_in.a, regs_in.b, regs_in.c) + regs_in.d + ss2 + w_p;
        tt2 = gg(hi, regs_in.e, regs_in.f, regs_in.g) + regs_in.h + ss1 + w_j;

        regs_nxt_c.a = tt1;
        regs_nxt_c.b = regs_in.a;
        regs_nxt_c.c = rol32(regs_in.b, 5'd9);
        regs_nxt_c.d = regs_in.c;
        regs_nxt_c.e = p0(tt2);
        regs_nxt_c.f = regs_in.e;
        regs_nxt_c.g = rol32(regs_in.f, 5'd19);
        regs_nxt_c.h = regs_in.g;
    end

    // W(j+16) enters at the top as W(j) drops out of the bottom
    always_comb begin
        w_new = p1(win_in[0] ^ win_in[7] ^ rol32(win_in[13], 5'd15))
              ^ rol32(win_in[3], 5'd7) ^ win_in[10];
        win_nxt_c = {w_new, win_in[WIN_N-1:1]};
    end

endmodule

// File: rtl/sm3_cf_core.sv
// Iterative SM3 compression function: V(i+1) = CF(V(i), B(i)) with a
// start/done handshake, RPC rounds per clock.
module sm3_cf_core
    import sm3_pkg::*;
#(
    parameter int unsigned RPC = 1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [HASH_W-1:0]  iv,
    input  logic [BLOCK_W-1:0] block,
    output logic [HASH_W-1:0]  hash_out,
    output logic               done,
    output logic               busy
);

    localparam logic [J_W-1:0] J_LAST = J_W'(ROUNDS - RPC);
    localparam logic [J_W-1:0] J_STEP = J_W'(RPC);

    if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
        $error("sm3_cf_core: RPC must be 1, 2 or 4");
    end

    state_t            state_q;
    state_t            state_d;
    logic              load;
    logic              step;
    logic              finish;

    logic [HASH_W-1:0] v_q;
    sm3_regs_t         regs_q;
    sm3_win_t          win_q;
    logic [J_W-1:0]    j_q;

    sm3_regs_t         rnd_regs [RPC];
    sm3_win_t          rnd_win  [RPC];
    sm3_regs_t         regs_last;
    sm3_win_t          win_last;

    // Unrolled round chain: stage k works on round j_q+k
    for (genvar k = 0; k < RPC; k++) begin : g_rnd
        sm3_regs_t r_in;
        sm3_win_t  w_in;
        if (k == 0) begin : g_first
            assign r_in = regs_q;
            assign w_in = win_q;
        end else begin : g_next
            assign r_in = rnd_regs[k-1];
            assign w_in = rnd_win[k-1];
        end
        sm3_round u_round (
            .regs_in    (r_in),
            .win_in     (w_in),
            .j          (j_q + J_W'(k)),
            .regs_nxt_c (rnd_regs[k]),
            .win_nxt_c  (rnd_win[k])
        );
    end

    assign regs_last = rnd_regs[RPC-1];
    assign win_last  = rnd_win[RPC-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; start only matters in IDLE
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (j_q == J_LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Working registers, round counter and result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q      <= '0;
            regs_q   <= '0;
            win_q    <= '0;
            j_q      <= '0;
            hash_out <= '0;
        end else begin
            if (load) begin
                v_q    <= iv;
                regs_q <= sm3_regs_t'(iv);
                win_q  <= load_win(block);
                j_q    <= '0;
            end else if (step) begin
                regs_q <= regs_last;
                win_q  <= win_last;
                j_q    <= finish ? '0 : j_q + J_STEP;
            end
            if (finish) begin
                hash_out <= v_q ^ HASH_W'(regs_last);
            end
        end
    end

    // Status flags follow the next state so they are valid with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= (state_d == DONE);
            busy <= (state_d != IDLE);
        end
    end

endmodule
